// File: rtl/hal_sync_pkg.sv
// Shared definitions for the HAL synchronizer family: sizing helper and
// structural limits used by hal_sync_filter and its per-bit filter.
package hal_sync_pkg;

    localparam int MIN_SYNC_DEPTH = 2;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hal_sync_filter_bit.sv
// One bit of the stability filter: counts consecutive cycles the synchronized
// input disagrees with dout, then follows it and emits a registered edge pulse.
module hal_sync_filter_bit
    import hal_sync_pkg::*;
#(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_VALUE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int              CW      = clog2_min1(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // NOTE: all state here updates with <= so every flop samples the same
    // pre-edge values; blocking assignments would chain dout into rise/fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VALUE;
            cnt  <= '0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                // Pulse lands on the same edge dout takes its new value.
                dout <= s;
                cnt  <= '0;
                rise <= s;
                fall <= ~s;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hal_sync_filter.sv
// WIDTH-bit level synchronizer with per-bit glitch filter and rise/fall pulses.
// Bits are independent; this is not a coherent bus synchronizer.
module hal_sync_filter
    import hal_sync_pkg::*;
#(
    parameter int               WIDTH         = 1,
    parameter int               DEPTH         = 2,
    parameter int               STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    if (DEPTH < MIN_SYNC_DEPTH) begin : g_depth_check
        $error("hal_sync_filter: DEPTH must be >= %0d", MIN_SYNC_DEPTH);
    end

    if (STABLE_CYCLES < 1) begin : g_stable_check
        $error("hal_sync_filter: STABLE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] stage [DEPTH];
    logic [WIDTH-1:0] s;

    // NOTE: the sync stages are reset to RESET_VALUE as well as dout, so the
    // filter sees s == dout at release and reset can never produce an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= RESET_VALUE;
            end
        end else begin
            stage[0] <= din;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign s = stage[DEPTH-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        hal_sync_filter_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VALUE   (RESET_VALUE[i])
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .s    (s[i]),
            .dout (dout[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule

// File: tb/tb_hal_sync_filter.sv
// Directed bench for hal_sync_filter: a filtering instance (D2/S4, RV 0101)
// and a pass-through instance (D3/S1, RV 0) sharing one clock.
module tb_hal_sync_filter;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] din_a, din_b;
    logic [3:0] dout_a, rise_a, fall_a;
    logic [3:0] dout_b, rise_b, fall_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hal_sync_filter #(
        .WIDTH(4), .DEPTH(2), .STABLE_CYCLES(4), .RESET_VALUE(4'b0101)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .din(din_a),
        .dout(dout_a), .rise(rise_a), .fall(fall_a)
    );

    hal_sync_filter #(
        .WIDTH(4), .DEPTH(3), .STABLE_CYCLES(1), .RESET_VALUE(4'b0000)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .din(din_b),
        .dout(dout_b), .rise(rise_b), .fall(fall_b)
    );

    // Inputs change right after a falling edge; outputs are sampled at falling edges.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        din_a = 4'b1010; din_b = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (dout_a !== 4'b0101 || rise_a !== 4'b0000 || fall_a !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d: dout=%b rise=%b fall=%b, need dout=0101 rise=0000 fall=0000",
                         c, dout_a, rise_a, fall_a);
            end
        end
        rst_a = 1'b0; rst_b = 1'b0;
        din_a = 4'b0101;
        tick();
        n_checks++;
        if (dout_a !== 4'b0101 || rise_a !== 4'b0000 || fall_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release: dout=%b rise=%b fall=%b, need dout=0101 rise=0000 fall=0000",
                     dout_a, rise_a, fall_a);
        end
        n_checks++;
        if (dout_b !== 4'b0000 || rise_b !== 4'b0000 || fall_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_release_b: dout=%b rise=%b fall=%b, need all zero",
                     dout_b, rise_b, fall_b);
        end
        for (int c = 0; c < 6; c++) tick();
    endtask

    // bit0 falls then rises; each change is visible exactly 6 ticks after driving.
    task automatic test_latency();
        logic [3:0] exp_d, exp_r, exp_f;
        din_a = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = (k >= 6) ? 4'b0100 : 4'b0101;
            exp_f = (k == 6) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (dout_a !== exp_d || rise_a !== 4'b0000 || fall_a !== exp_f) begin
                n_fail++;
                $display("FAIL latency_fall k=%0d: dout=%b rise=%b fall=%b, need dout=%b rise=0000 fall=%b",
                         k, dout_a, rise_a, fall_a, exp_d, exp_f);
            end
        end
        din_a = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = (k >= 6) ? 4'b0101 : 4'b0100;
            exp_r = (k == 6) ? 4'b0001 : 4'b0000;
            n_checks++;
            if (dout_a !== exp_d || rise_a !== exp_r || fall_a !== 4'b0000) begin
                n_fail++;
                $display("FAIL latency_rise k=%0d: dout=%b rise=%b fall=%b, need dout=%b rise=%b fall=0000",
                         k, dout_a, rise_a, fall_a, exp_d, exp_r);
            end
        end
    endtask

    // bit1: a 3-cycle pulse vanishes; a 4-cycle pulse gives rise at 6, fall at 10.
    task automatic test_min_pulse();
        logic [3:0] exp_d, exp_r, exp_f;
        for (int t = 0; t < 12; t++) begin
            din_a = (t < 3) ? 4'b0111 : 4'b0101;
            tick();
            n_checks++;
            if (dout_a !== 4'b0101 || rise_a !== 4'b0000 || fall_a !== 4'b0000) begin
                n_fail++;
                $display("FAIL short_pulse k=%0d: dout=%b rise=%b fall=%b, need dout=0101 rise=0000 fall=0000",
                         t + 1, dout_a, rise_a, fall_a);
            end
        end
        for (int t = 0; t < 14; t++) begin
            din_a = (t < 4) ? 4'b0111 : 4'b0101;
            tick();
            exp_d = (t + 1 >= 6 && t + 1 < 10) ? 4'b0111 : 4'b0101;
            exp_r = (t + 1 == 6)  ? 4'b0010 : 4'b0000;
            exp_f = (t + 1 == 10) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (dout_a !== exp_d || rise_a !== exp_r || fall_a !== exp_f) begin
                n_fail++;
                $display("FAIL full_pulse k=%0d: dout=%b rise=%b fall=%b, need dout=%b rise=%b fall=%b",
                         t + 1, dout_a, rise_a, fall_a, exp_d, exp_r, exp_f);
            end
        end
    endtask

    // bit2 chatter 1,1,1,0,1,1,1,1: the 0 restarts the count, rise lands at tick 10.
    task automatic test_chatter();
        logic [7:0] pattern;
        logic [3:0] exp_d, exp_r;
        pattern = 8'b1111_0111;
        din_a = 4'b0001;
        for (int c = 0; c < 8; c++) tick();
        n_checks++;
        if (dout_a !== 4'b0001) begin
            n_fail++;
            $display("FAIL chatter_setup: dout=%b, need 0001", dout_a);
        end
        for (int t = 0; t < 13; t++) begin
            din_a = (t < 8) ? {1'b0, pattern[t], 2'b01} : 4'b0101;
            tick();
            exp_d = (t + 1 >= 10) ? 4'b0101 : 4'b0001;
            exp_r = (t + 1 == 10) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (dout_a !== exp_d || rise_a !== exp_r || fall_a !== 4'b0000) begin
                n_fail++;
                $display("FAIL chatter k=%0d: dout=%b rise=%b fall=%b, need dout=%b rise=%b fall=0000",
                         t + 1, dout_a, rise_a, fall_a, exp_d, exp_r);
            end
        end
    endtask

    // STABLE_CYCLES=1, DEPTH=3: dout is din delayed 4 ticks, pulses on its edges.
    task automatic test_passthrough();
        logic [3:0] vec [24];
        logic [3:0] exp_d, prev_d;
        for (int t = 0; t < 24; t++) vec[t] = 4'($urandom_range(0, 15));
        vec[0] = 4'b1111;
        vec[1] = 4'b0000;
        for (int t = 0; t < 24; t++) begin
            din_b = vec[t];
            tick();
            exp_d  = (t + 1 >= 4) ? vec[t - 3] : 4'b0000;
            prev_d = (t + 1 >= 5) ? vec[t - 4] : 4'b0000;
            n_checks++;
            if (dout_b !== exp_d || rise_b !== (exp_d & ~prev_d) || fall_b !== (~exp_d & prev_d)) begin
                n_fail++;
                $display("FAIL passthrough k=%0d: dout=%b rise=%b fall=%b, need dout=%b rise=%b fall=%b",
                         t + 1, dout_b, rise_b, fall_b, exp_d, exp_d & ~prev_d, ~exp_d & prev_d);
            end
        end
        din_b = 4'b0000;
    endtask

    // bit3 rising; reset lands on the edge where cnt[3] would go 2->3.
    task automatic test_reset_mid_filter();
        logic [3:0] exp_d, exp_r;
        din_a = 4'b1101;
        for (int c = 0; c < 4; c++) tick();
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        n_checks++;
        if (dout_a !== 4'b0101 || rise_a !== 4'b0000 || fall_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_apply: dout=%b rise=%b fall=%b, need dout=0101 rise=0000 fall=0000",
                     dout_a, rise_a, fall_a);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_d = (k >= 6) ? 4'b1101 : 4'b0101;
            exp_r = (k == 6) ? 4'b1000 : 4'b0000;
            n_checks++;
            if (dout_a !== exp_d || rise_a !== exp_r || fall_a !== 4'b0000) begin
                n_fail++;
                $display("FAIL midreset_recount k=%0d: dout=%b rise=%b fall=%b, need dout=%b rise=%b fall=0000",
                         k, dout_a, rise_a, fall_a, exp_d, exp_r);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        din_a = 4'b0000; din_b = 4'b0000;
        tick();
        test_reset();
        test_latency();
        test_min_pulse();
        test_chatter();
        test_passthrough();
        test_reset_mid_filter();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
